// File: rtl/a51_sequencer.sv
// Control sequencer for an A5/1 keystream generator: steps three external
// shift registers through clear, key/frame load, mixing and keystream output.
module a51_sequencer #(
    parameter int KEY_BITS    = 64,
    parameter int FRAME_BITS  = 22,
    parameter int MIX_CYCLES  = 100,
    parameter int STREAM_BITS = 228
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [KEY_BITS-1:0]   key,
    input  logic [FRAME_BITS-1:0] frame,
    output logic                  busy,
    output logic                  done,
    output logic                  lfsr_load,
    output logic [2:0]            lfsr_clk_en,
    output logic                  lfsr_d,
    input  logic [2:0]            lfsr_clk_bit,
    input  logic [2:0]            lfsr_q,
    output logic                  ks_valid,
    output logic                  ks_bit,
    input  logic                  ks_ready,
    output logic [2:0]            dbg_state_o
);

    // Keystream handshake: a bit transfers on a cycle where ks_valid and
    // ks_ready are both high; ks_bit holds steady while ks_valid && !ks_ready.

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_KEY    = 3'd2,
        S_FRAME  = 3'd3,
        S_MIX    = 3'd4,
        S_STREAM = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    localparam logic [7:0] KEY_LAST    = 8'(KEY_BITS - 1);
    localparam logic [7:0] FRAME_LAST  = 8'(FRAME_BITS - 1);
    localparam logic [7:0] MIX_LAST    = 8'(MIX_CYCLES - 1);
    localparam logic [7:0] STREAM_LAST = 8'(STREAM_BITS - 1);

    state_t                  state_q;
    logic [7:0]              cnt_q;
    logic [KEY_BITS-1:0]     key_q;
    logic [FRAME_BITS-1:0]   frame_q;
    logic                    primed_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= 8'd0;
            key_q    <= '0;
            frame_q  <= '0;
            primed_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        key_q    <= key;
                        frame_q  <= frame;
                        primed_q <= 1'b0;
                        state_q  <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    cnt_q   <= KEY_LAST;
                    state_q <= S_KEY;
                end
                S_KEY: begin
                    key_q <= key_q >> 1;
                    if (cnt_q == 8'd0) begin
                        cnt_q   <= FRAME_LAST;
                        state_q <= S_FRAME;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                S_FRAME: begin
                    frame_q <= frame_q >> 1;
                    if (cnt_q == 8'd0) begin
                        cnt_q   <= MIX_LAST;
                        state_q <= S_MIX;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                S_MIX: begin
                    if (cnt_q == 8'd0) begin
                        cnt_q    <= STREAM_LAST;
                        primed_q <= 1'b0;
                        state_q  <= S_STREAM;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                S_STREAM: begin
                    // cnt_q counts bits still to deliver after the one on offer
                    if (!primed_q) begin
                        primed_q <= 1'b1;
                    end else if (ks_ready) begin
                        if (cnt_q == 8'd0) begin
                            state_q <= S_DONE;
                        end else begin
                            cnt_q <= cnt_q - 8'd1;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    logic       maj;
    logic [2:0] maj_en;

    always_comb begin
        maj = (lfsr_clk_bit[0] & lfsr_clk_bit[1]) |
              (lfsr_clk_bit[0] & lfsr_clk_bit[2]) |
              (lfsr_clk_bit[1] & lfsr_clk_bit[2]);
        maj_en = {lfsr_clk_bit[2] == maj, lfsr_clk_bit[1] == maj, lfsr_clk_bit[0] == maj};
        lfsr_clk_en = 3'b000;
        lfsr_d      = 1'b0;
        case (state_q)
            S_KEY: begin
                lfsr_clk_en = 3'b111;
                lfsr_d      = key_q[0];
            end
            S_FRAME: begin
                lfsr_clk_en = 3'b111;
                lfsr_d      = frame_q[0];
            end
            S_MIX: begin
                lfsr_clk_en = maj_en;
            end
            S_STREAM: begin
                // The final handshake must not advance the registers
                if (!primed_q || (ks_ready && cnt_q != 8'd0)) begin
                    lfsr_clk_en = maj_en;
                end
            end
            default: begin
                lfsr_clk_en = 3'b000;
            end
        endcase
    end

    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);
    assign lfsr_load   = (state_q == S_CLEAR);
    assign ks_valid    = (state_q == S_STREAM) && primed_q;
    assign ks_bit      = ks_valid & (^lfsr_q);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_a51_sequencer.sv
// Bench for a51_sequencer: behavioural R1/R2/R3 registers around the DUT and a
// software A5/1 reference feeding an expected-bit scoreboard.
module tb_a51_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic [63:0] key;
    logic [21:0] frame;
    logic        busy;
    logic        done;
    logic        lfsr_load;
    logic [2:0]  lfsr_clk_en;
    logic        lfsr_d;
    logic [2:0]  lfsr_clk_bit;
    logic [2:0]  lfsr_q;
    logic        ks_valid;
    logic        ks_bit;
    logic        ks_ready;
    logic [2:0]  dbg_state;

    a51_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .key          (key),
        .frame        (frame),
        .busy         (busy),
        .done         (done),
        .lfsr_load    (lfsr_load),
        .lfsr_clk_en  (lfsr_clk_en),
        .lfsr_d       (lfsr_d),
        .lfsr_clk_bit (lfsr_clk_bit),
        .lfsr_q       (lfsr_q),
        .ks_valid     (ks_valid),
        .ks_bit       (ks_bit),
        .ks_ready     (ks_ready),
        .dbg_state_o  (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // behavioural shift registers driven by the sequencer
    logic [18:0] r1;
    logic [21:0] r2;
    logic [22:0] r3;
    logic        force_en;
    logic [2:0]  force_val;

    always @(posedge clk or posedge reset) begin
        if (reset || lfsr_load) begin
            r1 <= '0;
            r2 <= '0;
            r3 <= '0;
        end else begin
            if (lfsr_clk_en[0]) r1 <= {r1[17:0], r1[18] ^ r1[17] ^ r1[16] ^ r1[13] ^ lfsr_d};
            if (lfsr_clk_en[1]) r2 <= {r2[20:0], r2[21] ^ r2[20] ^ lfsr_d};
            if (lfsr_clk_en[2]) r3 <= {r3[21:0], r3[22] ^ r3[21] ^ r3[20] ^ r3[7] ^ lfsr_d};
        end
    end

    assign lfsr_clk_bit = force_en ? force_val : {r3[10], r2[10], r1[8]};
    assign lfsr_q       = {r3[22], r2[21], r1[18]};

    // scoreboard and counters
    logic [0:0] exp_q[$];
    logic       ref_bits[0:227];
    logic       rx_bits[0:227];
    int         rx_cnt;
    int         stalls;
    int         checks;
    int         errors;
    logic       stall_prev;
    logic       bit_prev;
    logic       bp_mode;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // software A5/1 reference: bit k after 101+k majority clocks
    task automatic a51_ref(input logic [63:0] k, input logic [21:0] f);
        logic [18:0] a;
        logic [21:0] b;
        logic [22:0] c;
        logic        m;
        logic        ca, cb, cc;
        a = '0; b = '0; c = '0;
        for (int i = 0; i < 86; i++) begin
            m = (i < 64) ? k[i] : f[i-64];
            a = {a[17:0], a[18] ^ a[17] ^ a[16] ^ a[13] ^ m};
            b = {b[20:0], b[21] ^ b[20] ^ m};
            c = {c[21:0], c[22] ^ c[21] ^ c[20] ^ c[7] ^ m};
        end
        for (int i = 0; i < 328; i++) begin
            ca = a[8]; cb = b[10]; cc = c[10];
            m = (ca & cb) | (ca & cc) | (cb & cc);
            if (ca == m) a = {a[17:0], a[18] ^ a[17] ^ a[16] ^ a[13]};
            if (cb == m) b = {b[20:0], b[21] ^ b[20]};
            if (cc == m) c = {c[21:0], c[22] ^ c[21] ^ c[20] ^ c[7]};
            if (i >= 100) ref_bits[i-100] = a[18] ^ b[21] ^ c[22];
        end
    endtask

    // consumer ready, pseudo-random when backpressure is on
    initial begin
        ks_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            ks_ready = bp_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    // output monitor
    always @(negedge clk) begin
        if (!reset) begin
            if (stall_prev && ks_valid) check("stall_hold", 64'(ks_bit), 64'(bit_prev));
            if (ks_valid && !ks_ready) begin
                stalls++;
                check("stall_en", 64'(lfsr_clk_en), 64'(0));
            end
            if (ks_valid && ks_ready) begin
                if (exp_q.size() == 0) begin
                    check("sb_empty", 64'(1), 64'(0));
                end else begin
                    check("ks_bit", 64'(ks_bit), 64'(exp_q.pop_front()));
                end
                if (rx_cnt < 228) rx_bits[rx_cnt] = ks_bit;
                rx_cnt++;
            end
            stall_prev = ks_valid && !ks_ready;
            bit_prev   = ks_bit;
        end else begin
            stall_prev = 1'b0;
        end
    end

    // mode: 0 plain, 1 backpressure, 2 start while busy, 3 reset at 300, 4 load sequencing
    task automatic run_vector(input logic [63:0] k, input logic [21:0] f, input int mode);
        int         n;
        logic [7:0] b0;
        logic [7:0] b1;
        a51_ref(k, f);
        exp_q.delete();
        for (int i = 0; i < 228; i++) exp_q.push_back(ref_bits[i]);
        rx_cnt  = 0;
        stalls  = 0;
        bp_mode = (mode == 1);
        @(negedge clk);
        key   = k;
        frame = f;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) check("busy_first", 64'(busy), 64'(1));
            if (mode == 2 && n == 50) begin
                start = 1'b1;
                key   = ~k;
                frame = ~f;
            end
            if (mode == 2 && n == 51) start = 1'b0;
            if (mode == 4 && n <= 187) begin
                check("lfsr_load", 64'(lfsr_load), 64'(n == 1));
                check("lfsr_d", 64'(lfsr_d), 64'(n == 2));
                if (n >= 2 && n <= 87) check("en_load", 64'(lfsr_clk_en), 64'(3'b111));
                if (n == 120) begin
                    force_en  = 1'b1;
                    force_val = 3'b011;
                    #1 check("maj_011", 64'(lfsr_clk_en), 64'(3'b011));
                    force_val = 3'b100;
                    #1 check("maj_100", 64'(lfsr_clk_en), 64'(3'b011));
                    force_val = 3'b000;
                    #1 check("maj_000", 64'(lfsr_clk_en), 64'(3'b111));
                    force_en = 1'b0;
                end
            end
            if (mode == 3 && n == 300) begin
                #2 reset = 1'b1;
                #1;
                check("rst_valid", 64'(ks_valid), 64'(0));
                check("rst_busy", 64'(busy), 64'(0));
                check("rst_en", 64'(lfsr_clk_en), 64'(0));
                repeat (2) @(negedge clk);
                reset = 1'b0;
                exp_q.delete();
                return;
            end
        end while (!done && n < 2000);
        if (!done) begin
            check("done_timeout", 64'(0), 64'(1));
        end else begin
            check("done_cycle", 64'(n), 64'(417 + stalls));
            check("busy_done", 64'(busy), 64'(1));
        end
        @(negedge clk);
        check("done_pulse", 64'(done), 64'(0));
        check("busy_after", 64'(busy), 64'(0));
        check("rx_count", 64'(rx_cnt), 64'(228));
        check("sb_left", 64'(exp_q.size()), 64'(0));
        if (mode != 4) begin
            b0 = '0;
            b1 = '0;
            for (int i = 0; i < 8; i++) begin
                b0 = {b0[6:0], rx_bits[i]};
                b1 = {b1[6:0], rx_bits[i+8]};
            end
            check("byte0", 64'(b0), 64'(8'h53));
            check("byte1", 64'(b1), 64'(8'h4E));
        end
        bp_mode = 1'b0;
    endtask

    localparam logic [63:0] GSM_KEY   = 64'hEFCDAB8967452312;
    localparam logic [21:0] GSM_FRAME = 22'h134;

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        key        = '0;
        frame      = '0;
        force_en   = 1'b0;
        force_val  = 3'b000;
        bp_mode    = 1'b0;
        checks     = 0;
        errors     = 0;
        rx_cnt     = 0;
        stalls     = 0;
        stall_prev = 1'b0;
        bit_prev   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy0", 64'(busy), 64'(0));
        check("rst_done0", 64'(done), 64'(0));
        check("rst_load0", 64'(lfsr_load), 64'(0));
        check("rst_en0", 64'(lfsr_clk_en), 64'(0));
        check("rst_d0", 64'(lfsr_d), 64'(0));
        check("rst_valid0", 64'(ks_valid), 64'(0));
        check("rst_bit0", 64'(ks_bit), 64'(0));
        reset = 1'b0;
        @(negedge clk);
        check("idle_busy", 64'(busy), 64'(0));

        run_vector(GSM_KEY, GSM_FRAME, 0);
        run_vector(GSM_KEY, GSM_FRAME, 1);
        run_vector(GSM_KEY, GSM_FRAME, 2);
        run_vector(GSM_KEY, GSM_FRAME, 3);
        run_vector(GSM_KEY, GSM_FRAME, 0);
        run_vector(64'h1, 22'h0, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/a51_sequencer.md
# a51_sequencer

Control sequencer for the A5/1 keystream generator. It drives the three shared-input shift-register instances (R1/R2/R3) through reset, key load, frame load and 100 mixing clocks, then 228 keystream clocks. It serialises the 64-bit session key and 22-bit frame number into the registers' feedback input. It applies majority clocking from the registers' clocking bits and presents the keystream one bit at a time on a valid/ready interface.

## Interface

Parameters:
- KEY_BITS, 64, session key length, shifted LSB first
- FRAME_BITS, 22, frame number length, shifted LSB first
- MIX_CYCLES, 100, majority-clocked cycles with output discarded
- STREAM_BITS, 228, keystream bits delivered per start

Ports:
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-high; forces IDLE
- start  in  1  begin a run; sampled only in IDLE
- key  in  KEY_BITS  session key, captured when start is accepted
- frame  in  FRAME_BITS  frame number, captured when start is accepted
- busy  out  1  high from the cycle after start is accepted through the DONE cycle
- done  out  1  one-cycle pulse after the last keystream bit is accepted
- lfsr_load  out  1  synchronous clear to all three registers
- lfsr_clk_en  out  3  per-register shift enable, bit 0 = R1
- lfsr_d  out  1  serial data bit, common to all three registers
- lfsr_clk_bit  in  3  clocking bit from R1/R2/R3
- lfsr_q  in  3  output (MSB) bit from R1/R2/R3
- ks_valid  out  1  keystream bit available
- ks_bit  out  1  keystream bit, XOR of lfsr_q; 0 when ks_valid low
- ks_ready  in  1  consumer accepts ks_bit

## Operation

- States: IDLE, CLEAR, KEY, FRAME, MIX, STREAM, DONE. One down-counter, 8 bits, sized to the largest phase.
- IDLE: all outputs 0. start=1 captures key and frame into shadow registers, then goes to CLEAR.
- CLEAR: 1 cycle. lfsr_load=1, lfsr_clk_en=0. Goes to KEY.
- KEY: KEY_BITS cycles. lfsr_clk_en=3'b111. lfsr_d = key bit n on the n-th cycle, starting at n=0.
- FRAME: FRAME_BITS cycles, same as KEY using frame bits.
- MIX: MIX_CYCLES cycles. lfsr_d=0. Majority clocking applies.
- Majority clocking: maj = majority(lfsr_clk_bit). lfsr_clk_en[i] = (lfsr_clk_bit[i] == maj), so at least two registers shift.
- STREAM:
  - Performs STREAM_BITS majority clocks in total, with lfsr_d=0.
  - Entry cycle: one majority clock, ks_valid=0.
  - From then on, ks_valid=1 and ks_bit = ^lfsr_q, which is combinational from the current register state.
  - On ks_valid && ks_ready with more bits remaining: majority clock, ks_valid stays 1.
  - On the final handshake: no clock, go to DONE.
  - ks_ready=0: lfsr_clk_en=0 and ks_bit is held stable.
- Bit k (k=0..227) equals the XOR of the MSBs after MIX_CYCLES+1+k majority clocks.
- DONE: 1 cycle. done=1, busy=1. Then IDLE.
- start outside IDLE: ignored; the shadow key and frame are unaffected.
- Reset mid-run: immediate return to IDLE, all outputs 0. The registers are cleared by their own reset or by the next CLEAR.

## Timing

- Reset values: busy, done, lfsr_load, lfsr_clk_en, lfsr_d, ks_valid and ks_bit are all 0.
- Timeline, with start accepted at edge 0 and ks_ready held high:

| Cycles | Phase |
|---|---|
| 1 | CLEAR (lfsr_load) |
| 2–65 | KEY |
| 66–87 | FRAME |
| 88–187 | MIX |
| 188 | first stream clock |
| 189–416 | ks_valid=1, one bit per cycle |
| 417 | done |
| 418 | busy=0; a new start is accepted |

- Each cycle with ks_ready low adds exactly one cycle to the timeline.
- Outputs to the registers are combinational from state, counter and lfsr_clk_bit. The registers' enables act on the same edge.

## Test plan

- GSM reference vector:
  - Stimulus: key=64'hEFCDAB8967452312, frame=22'h134, ks_ready=1.
  - Response: the first 8 bits packed MSB-first equal 8'h53, and the next 8 bits equal 8'h4E.
  - 228 bits total, and done occurs exactly 417 cycles after start.
- Backpressure:
  - Stimulus: same vector with ks_ready toggled pseudo-randomly.
  - Response: the bit sequence is identical to the previous test.
  - lfsr_clk_en=0 on every cycle where ks_valid=1 and ks_ready=0.
  - ks_bit is stable while stalled.
- Load sequencing:
  - Stimulus: key=64'h1, frame=0.
  - Response: lfsr_load=1 in cycle 1 only; lfsr_d=1 in cycle 2 only, then 0 through MIX.
  - lfsr_clk_en=3'b111 in cycles 2–87.
- Majority clocking:
  - Stimulus: force lfsr_clk_bit to 3'b011, 3'b100 and 3'b000 during MIX.
  - Response: lfsr_clk_en is 3'b011, 3'b011 and 3'b111 respectively.
- start while busy:
  - Stimulus: assert start with a different key at cycle 50.
  - Response: no effect; the output matches the original vector.
- Reset mid-STREAM:
  - Stimulus: assert reset at cycle 300.
  - Response: ks_valid=0 and busy=0 immediately.
  - After reset is released, a fresh start reproduces the vector from its first bit.
